inbuf: RTL and testbench

Per-port input buffer and route-request stage sitting directly upstream of the crossbar `cb`; one instance drives each of the crossbar's `co0`..`co3` inputs. It stores incoming flits in a small FIFO, decodes the destination port from each header flit, and raises a one-hot request toward that output. Once the crossbar-side arbiter grants the request, it streams the packet's body and tail flits onto `odata`, one flit per cycle.

---
 rtl/inbuf_pkg.sv | 26 ++
 rtl/flit_fifo.sv | 58 +++++
 rtl/inbuf.sv | 95 +++++++++
 tb/tb_inbuf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/inbuf_pkg.sv
// Shared definitions for the input buffer: flit geometry, flit type codes,
// FSM state encodings and a one-hot helper for the route request.
package inbuf_pkg;

  // Flit is PKTW+1 bits: [9:8] type, [7:0] payload. Crossbar has PORT+1 outputs.
  localparam int PKTW = 9;
  localparam int PORT = 3;

  localparam logic [1:0] FT_NONE = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  // FSM states, kept as plain constants so older tools can consume them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  function automatic logic [PORT:0] onehot(input logic [1:0] d);
    logic [PORT:0] r;
    r    = '0;
    r[d] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO for flits. Head is read combinationally from the
// storage array; full is a registered flag tracking count == DEPTH.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          wr_en;
  logic          rd_en;

  // A push while full is discarded, even if a pop happens in the same cycle.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH (power of two); full mirrors the new count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/inbuf.sv
// Per-port input buffer and route-request stage in front of the crossbar.
// Buffers flits, decodes the header destination, requests that output and
// streams the packet once granted.
//
// Request/grant: req is one-hot on the destination and stays high from the
// REQ state until the edge that pops the TAIL. A flit transfers at a rising
// edge when grant[dst] is high and odata carries a non-NONE flit; the
// flit is popped at that edge. With grant low (or FIFO empty in XFER)
// odata is 0 and nothing moves.
module inbuf
  import inbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PKTW:0] idata,
  output logic          full,
  output logic [PKTW:0] odata,
  output logic [PORT:0] req,
  input  logic [PORT:0] grant
);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    dst;
  logic [PKTW:0] head;
  logic [1:0]    head_type;
  logic          empty;
  logic          push;
  logic          pop;

  assign push      = (idata[PKTW -: 2] != FT_NONE);
  assign head_type = head[PKTW -: 2];

  flit_fifo #(
    .DEPTH (DEPTH),
    .W     (PKTW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (idata),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  // Next-state, pop and output decode from the current state and FIFO head.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    req        = '0;
    odata      = '0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (head_type == FT_HEAD) state_next = ST_REQ;
          else                      pop        = 1'b1;  // orphan body/tail
        end
      end
      ST_REQ: begin
        odata = head;
        req   = onehot(dst);
        if (grant[dst]) begin
          pop        = 1'b1;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        req = onehot(dst);
        if (grant[dst] && !empty) begin
          odata = head;
          pop   = 1'b1;
          // Only a TAIL ends the packet; a stray HEAD is forwarded as data.
          if (head_type == FT_TAIL) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and destination latch taken from the header in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dst   <= 2'd0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && !empty && head_type == FT_HEAD) dst <= head[1:0];
    end
  end

endmodule

// File: tb/tb_inbuf.sv
// Self-checking bench for inbuf: directed packet scenarios plus a scoreboard
// that matches every flit accepted by the crossbar against an expected queue.
module tb_inbuf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] idata;
  logic       full;
  logic [9:0] odata;
  logic [3:0] req;
  logic [3:0] grant;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp_flit;

  inbuf #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .idata (idata),
    .full  (full),
    .odata (odata),
    .req   (req),
    .grant (grant)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit for one cycle; fwd says whether it should reach odata.
  task automatic put(input logic [9:0] f, input bit fwd);
    if (fwd) exp_q.push_back(f);
    idata = f;
    tick();
    idata = '0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (req !== 4'b0000 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_req", req, 4'b0000);
  endtask

  // Scoreboard: a transfer happens where the granted request sees a real flit.
  always @(negedge clk) begin
    if (rst_n && (|(req & grant)) && odata[9:8] != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", odata, 10'h000);
      end else begin
        exp_flit = exp_q.pop_front();
        chk("sb_flit", odata, exp_flit);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idata = '0;
    grant = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 4'b0000);
    chk("rst_odata", odata, 10'h000);
    chk("rst_full", full, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic packet to port 3
    put(10'h203, 1);
    chk("t1_req_idle", req, 4'b0000);
    put(10'h100, 1);
    chk("t1_req", req, 4'b1000);
    chk("t1_hdr", odata, 10'h203);
    put(10'h101, 1);
    chk("t1_req_hold", req, 4'b1000);
    grant = 4'b1000;
    put(10'h102, 1);
    chk("t1_b0", odata, 10'h100);
    put(10'h103, 1);
    chk("t1_b1", odata, 10'h101);
    put(10'h300, 1);
    chk("t1_b2", odata, 10'h102);
    tick();
    chk("t1_b3", odata, 10'h103);
    tick();
    chk("t1_tail", odata, 10'h300);
    chk("t1_req_tail", req, 4'b1000);
    tick();
    chk("t1_req_done", req, 4'b0000);
    chk("t1_odata_done", odata, 10'h000);

    // Grant withdrawn mid-body
    grant = 4'b0000;
    put(10'h202, 1);
    put(10'h110, 1);
    put(10'h111, 1);
    put(10'h112, 1);
    grant = 4'b0100;
    tick();
    chk("t2_b0", odata, 10'h110);
    tick();
    grant = 4'b0000;
    #1;
    chk("t2_stall0", odata, 10'h000);
    chk("t2_stall_req", req, 4'b0100);
    tick();
    chk("t2_stall1", odata, 10'h000);
    tick();
    grant = 4'b0100;
    #1;
    chk("t2_resume", odata, 10'h111);
    put(10'h313, 1);
    wait_idle(20);

    // Fill past DEPTH with no grant
    grant = 4'b0000;
    put(10'h200, 1);
    put(10'h120, 1);
    put(10'h121, 1);
    chk("t3_full3", full, 1'b0);
    put(10'h122, 1);
    chk("t3_full4", full, 1'b1);
    put(10'h1ff, 0);
    chk("t3_full5", full, 1'b1);
    grant = 4'b0001;
    #1;
    chk("t3_hdr", odata, 10'h200);
    tick();
    chk("t3_full_fall", full, 1'b0);
    put(10'h3ab, 1);
    wait_idle(20);

    // Orphan flits in IDLE
    grant = 4'b0000;
    put(10'h155, 0);
    chk("t4_req0", req, 4'b0000);
    chk("t4_odata0", odata, 10'h000);
    put(10'h366, 0);
    chk("t4_req1", req, 4'b0000);
    chk("t4_odata1", odata, 10'h000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_req_idle", req, 4'b0000);
      chk("t4_odata_idle", odata, 10'h000);
    end

    // Back-to-back packets to ports 1 and 2
    grant = 4'b0110;
    put(10'h201, 1);
    chk("t5_req_a", req, 4'b0000);
    put(10'h1a1, 1);
    chk("t5_req_b", req, 4'b0010);
    chk("t5_hdr1", odata, 10'h201);
    put(10'h3a2, 1);
    chk("t5_req_c", req, 4'b0010);
    put(10'h202, 1);
    chk("t5_req_d", req, 4'b0010);
    chk("t5_tail1", odata, 10'h3a2);
    put(10'h1b1, 1);
    chk("t5_req_gap", req, 4'b0000);
    chk("t5_odata_gap", odata, 10'h000);
    put(10'h3b2, 1);
    chk("t5_req_e", req, 4'b0100);
    chk("t5_hdr2", odata, 10'h202);
    tick();
    chk("t5_req_f", req, 4'b0100);
    tick();
    chk("t5_req_g", req, 4'b0100);
    tick();
    chk("t5_req_h", req, 4'b0000);

    // Reset asserted during XFER
    grant = 4'b0001;
    put(10'h200, 1);
    put(10'h1c0, 1);
    put(10'h1c1, 1);
    chk("t6_xfer_req", req, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", req, 4'b0000);
    chk("t6_rst_odata", odata, 10'h000);
    chk("t6_rst_full", full, 1'b0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_req", req, 4'b0000);
    chk("t6_post_odata", odata, 10'h000);
    grant = 4'b0010;
    put(10'h201, 1);
    put(10'h1d0, 1);
    chk("t6_new_req", req, 4'b0010);
    put(10'h3d1, 1);
    wait_idle(20);

    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
